instr_encoder: RTL and testbench

RV32I instruction encoder: accepts field-level instruction requests (class, funct3, registers, immediate) over a valid/ready handshake and emits packed 32-bit instruction words, each tagged with a sequential word address. It is the inverse of the main decode path. It is used by the boot/self-test loader to build program images in instruction memory. A one-entry registered output stage carries the result. An optional state machine expands the LI pseudo-instruction into LUI+ADDI.

---
 rtl/instr_encoder_if.sv | 31 +++
 rtl/instr_encoder.sv | 196 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: field-level requests in, packed RV32I words out.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_kind;
    logic [2:0]        req_funct3;
    logic              req_alt;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [31:0]       req_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;

    modport master (
        output req_valid, req_kind, req_funct3, req_alt, req_rd, req_rs1, req_rs2, req_imm,
        output out_ready,
        input  req_ready, out_valid, out_instr, out_addr, err
    );

    modport slave (
        input  req_valid, req_kind, req_funct3, req_alt, req_rd, req_rs1, req_rs2, req_imm,
        input  out_ready,
        output req_ready, out_valid, out_instr, out_addr, err
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder with a one-entry registered output stage and word address counter.
// Define INSTR_ENC_LI_EN to compile in the LI pseudo-instruction (LUI+ADDI expansion).
module instr_encoder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input logic            clk,
    input logic            rst,
    instr_encoder_if.slave bus
);
    localparam logic [3:0] KOpImm  = 4'd0;
    localparam logic [3:0] KOp     = 4'd1;
    localparam logic [3:0] KLoad   = 4'd2;
    localparam logic [3:0] KStore  = 4'd3;
    localparam logic [3:0] KBranch = 4'd4;
    localparam logic [3:0] KJal    = 4'd5;
    localparam logic [3:0] KJalr   = 4'd6;
    localparam logic [3:0] KLui    = 4'd7;
    localparam logic [3:0] KAuipc  = 4'd8;

    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

`ifdef INSTR_ENC_LI_EN
    localparam logic [3:0] KLi = 4'd9;
    typedef enum logic {StIdle, StLiLo} state_e;
`else
    typedef enum logic {StIdle} state_e;
`endif

    logic [3:0]         kind;
    logic [2:0]         f3;
    logic               alt;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [31:0]        imm;
    logic signed [31:0] simm;

    assign kind = bus.req_kind;
    assign f3   = bus.req_funct3;
    assign alt  = bus.req_alt;
    assign rd   = bus.req_rd;
    assign rs1  = bus.req_rs1;
    assign rs2  = bus.req_rs2;
    assign imm  = bus.req_imm;
    assign simm = $signed(bus.req_imm);

    logic i_ok, b_ok, j_ok, shamt_ok, is_shift, alt_ok;

    assign i_ok     = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign b_ok     = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
    assign j_ok     = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];
    assign shamt_ok = (imm[31:5] == 27'd0);
    assign is_shift = (f3 == 3'd1) || (f3 == 3'd5);
    assign alt_ok   = !alt
                    || ((kind == KOp) && ((f3 == 3'd0) || (f3 == 3'd5)))
                    || ((kind == KOpImm) && (f3 == 3'd5));

    state_e             state_q;
    logic               out_valid_q;
    logic [31:0]        out_instr_q;
    logic [ADDR_W-1:0]  out_addr_q;
    logic               err_q;
    logic [31:0]        word;
    logic               illegal;
    logic               accept;
    logic               out_hs;

`ifdef INSTR_ENC_LI_EN
    logic [31:0] li_sum;
    logic [31:0] lo_word;
    logic [31:0] lo_q;
    logic        li_two;

    // Rounding the upper part absorbs the sign of the low 12 bits added back by the ADDI.
    assign li_sum  = imm + 32'h0000_0800;
    assign lo_word = {imm[11:0], rd, 3'b000, rd, OpcOpImm};
`endif

    always_comb begin
        word    = '0;
        illegal = 1'b0;
`ifdef INSTR_ENC_LI_EN
        li_two  = 1'b0;
`endif
        case (kind)
            KOpImm: begin
                if (is_shift) begin
                    illegal = !shamt_ok;
                    word    = {1'b0, alt, 5'b0, imm[4:0], rs1, f3, rd, OpcOpImm};
                end else begin
                    illegal = !i_ok;
                    word    = {imm[11:0], rs1, f3, rd, OpcOpImm};
                end
            end
            KOp:     word = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, OpcOp};
            KLoad: begin
                illegal = !i_ok || (f3 == 3'd3) || (f3[2:1] == 2'b11);
                word    = {imm[11:0], rs1, f3, rd, OpcLoad};
            end
            KStore: begin
                illegal = !i_ok || (f3 > 3'd2);
                word    = {imm[11:5], rs2, rs1, f3, imm[4:0], OpcStore};
            end
            KBranch: begin
                illegal = !b_ok || (f3[2:1] == 2'b01);
                word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OpcBranch};
            end
            KJal: begin
                illegal = !j_ok;
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpcJal};
            end
            KJalr: begin
                illegal = !i_ok;
                word    = {imm[11:0], rs1, 3'b000, rd, OpcJalr};
            end
            KLui:    word = {imm[31:12], rd, OpcLui};
            KAuipc:  word = {imm[31:12], rd, OpcAuipc};
`ifdef INSTR_ENC_LI_EN
            KLi: begin
                if (i_ok) begin
                    word = {imm[11:0], 5'd0, 3'b000, rd, OpcOpImm};
                end else begin
                    word   = {li_sum[31:12], rd, OpcLui};
                    li_two = (imm[11:0] != 12'd0);
                end
            end
`endif
            default: illegal = 1'b1;
        endcase
        if (!alt_ok) begin
            illegal = 1'b1;
        end
    end

    assign bus.req_ready = !rst && (state_q == StIdle) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign out_hs        = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= ADDR_W'(BASE_ADDR);
            err_q       <= 1'b0;
`ifdef INSTR_ENC_LI_EN
            lo_q        <= '0;
`endif
        end else begin
            err_q <= accept && illegal;
            if (out_hs) begin
                out_addr_q <= out_addr_q + ADDR_W'(1);
            end
            case (state_q)
                StIdle: begin
                    if (accept && !illegal) begin
                        out_valid_q <= 1'b1;
                        out_instr_q <= word;
`ifdef INSTR_ENC_LI_EN
                        if (li_two) begin
                            state_q <= StLiLo;
                            lo_q    <= lo_word;
                        end
`endif
                    end else if (out_hs) begin
                        out_valid_q <= 1'b0;
                    end
                end
`ifdef INSTR_ENC_LI_EN
                // LUI half is leaving; the ADDI half takes its place with out_valid kept high.
                StLiLo: begin
                    if (out_hs) begin
                        out_instr_q <= lo_q;
                        state_q     <= StIdle;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, corner sequences and a random run
// scored against an ISA-level reference model.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(10)) bus ();
    instr_encoder_if #(.ADDR_W(2))  bus2 ();

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (.clk(clk), .rst(rst), .bus(bus));
    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        int          kind;
        int          f3;
        int          alt;
        int          rd;
        int          rs1;
        int          rs2;
        logic [31:0] imm;
    } req_t;

    typedef struct {
        req_t        r;
        logic [31:0] instr;
        bit          bad;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [9:0]  exp_addr = '0;
    logic        err_exp  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic req_t mk(input int kind, input int f3, input int alt, input int rd,
                                input int rs1, input int rs2, input logic [31:0] imm);
        req_t r;
        r.kind = kind; r.f3 = f3; r.alt = alt; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        return r;
    endfunction

    function automatic logic [31:0] itype(input int imm, input int rs1, input int f3,
                                          input int rd, input int op);
        return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    endfunction

    // ISA-level reference: legality by integer ranges, encoding by field arithmetic.
    function automatic void ref_model(input req_t r, output bit bad, output int n,
                                      output logic [31:0] w0, output logic [31:0] w1);
        int  si;
        int  k;
        bit  sh;
        si  = $signed(r.imm);
        k   = r.kind;
        sh  = (k == 0) && (r.f3 == 1 || r.f3 == 5);
        bad = 0; n = 1; w0 = '0; w1 = '0;
        if (k > 9) bad = 1;
`ifndef INSTR_ENC_LI_EN
        if (k == 9) bad = 1;
`endif
        if (k == 2 && (r.f3 == 3 || r.f3 >= 6)) bad = 1;
        if (k == 3 && r.f3 > 2) bad = 1;
        if (k == 4 && (r.f3 == 2 || r.f3 == 3)) bad = 1;
        if (r.alt != 0 && !((k == 1 && (r.f3 == 0 || r.f3 == 5)) || (k == 0 && r.f3 == 5)))
            bad = 1;
        if (((k == 0 && !sh) || k == 2 || k == 3 || k == 6) && (si < -2048 || si > 2047))
            bad = 1;
        if (k == 4 && (si < -4096 || si > 4094 || (si % 2) != 0)) bad = 1;
        if (k == 5 && (si < -1048576 || si > 1048574 || (si % 2) != 0)) bad = 1;
        if (sh && (si < 0 || si > 31)) bad = 1;
        if (bad) begin
            n = 0;
            return;
        end
        case (k)
            0: w0 = itype(sh ? (r.alt * 1024 + si) : si, r.rs1, r.f3, r.rd, 'h13);
            1: w0 = (r.alt << 30) | (r.rs2 << 20) | (r.rs1 << 15) | (r.f3 << 12) | (r.rd << 7)
                    | 'h33;
            2: w0 = itype(si, r.rs1, r.f3, r.rd, 'h03);
            3: w0 = (((si >> 5) & 'h7F) << 25) | (r.rs2 << 20) | (r.rs1 << 15) | (r.f3 << 12)
                    | ((si & 'h1F) << 7) | 'h23;
            4: w0 = (((si >> 12) & 1) << 31) | (((si >> 5) & 'h3F) << 25) | (r.rs2 << 20)
                    | (r.rs1 << 15) | (r.f3 << 12) | (((si >> 1) & 'hF) << 8)
                    | (((si >> 11) & 1) << 7) | 'h63;
            5: w0 = (((si >> 20) & 1) << 31) | (((si >> 1) & 'h3FF) << 21)
                    | (((si >> 11) & 1) << 20) | (((si >> 12) & 'hFF) << 12) | (r.rd << 7) | 'h6F;
            6: w0 = itype(si, r.rs1, 0, r.rd, 'h67);
            7: w0 = (r.imm & 32'hFFFFF000) | (r.rd << 7) | 'h37;
            8: w0 = (r.imm & 32'hFFFFF000) | (r.rd << 7) | 'h17;
            default: begin
                if (si >= -2048 && si <= 2047) begin
                    w0 = itype(si, 0, 0, r.rd, 'h13);
                end else begin
                    w0 = ((r.imm + 32'h800) & 32'hFFFFF000) | (r.rd << 7) | 'h37;
                    if ((r.imm & 32'hFFF) != 0) begin
                        n  = 2;
                        w1 = itype(int'(r.imm & 32'hFFF), r.rd, 0, r.rd, 'h13);
                    end
                end
            end
        endcase
    endfunction

    task automatic monitor_step();
        req_t        r;
        bit          bad;
        int          n;
        logic [31:0] w0, w1;
        if (rst) begin
            exp_q.delete();
            exp_addr = '0;
            err_exp  = 1'b0;
            return;
        end
        check("err", 32'(bus.err), 32'(err_exp));
        check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        if (bus.out_valid && exp_q.size() != 0) begin
            check("out_instr", bus.out_instr, exp_q[0]);
            check("out_addr", 32'(bus.out_addr), 32'(exp_addr));
            if (bus.out_ready) begin
                void'(exp_q.pop_front());
                exp_addr = exp_addr + 10'd1;
            end
        end
        err_exp = 1'b0;
        if (bus.req_valid && bus.req_ready) begin
            r = mk(int'(bus.req_kind), int'(bus.req_funct3), int'(bus.req_alt), int'(bus.req_rd),
                   int'(bus.req_rs1), int'(bus.req_rs2), bus.req_imm);
            ref_model(r, bad, n, w0, w1);
            err_exp = bad;
            if (n >= 1) exp_q.push_back(w0);
            if (n == 2) exp_q.push_back(w1);
        end
    endtask

    initial forever begin
        @(negedge clk);
        monitor_step();
    end

    task automatic drive(input req_t r);
        bus.req_kind   = 4'(r.kind);
        bus.req_funct3 = 3'(r.f3);
        bus.req_alt    = 1'(r.alt);
        bus.req_rd     = 5'(r.rd);
        bus.req_rs1    = 5'(r.rs1);
        bus.req_rs2    = 5'(r.rs2);
        bus.req_imm    = r.imm;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input req_t r);
        drive(r);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                @(posedge clk);
                #1;
                bus.req_valid = 1'b0;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got req_ready=0 for 20 cycles, expected acceptance");
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus2.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] edges[14] = '{32'd2047, 32'd2048, -32'd2048, -32'd2049, 32'd4094, 32'd4095,
                                   -32'd4096, -32'd4098, 32'd1048574, 32'd1048576,
                                   -32'd1048576, 32'd31, 32'd32, 32'd0};
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 80)) - 32'd40;
            1: return edges[$urandom_range(0, 13)];
            2: return 32'($urandom);
            3: return (32'($urandom) & 32'h1FFF) - 32'h1000;
            4: return (32'($urandom) & 32'h1FFFFF) - 32'h100000;
            default: return 32'($urandom) & 32'h1F;
        endcase
    endfunction

    vec_t vecs[$];

    initial begin
        vec_t v;
        vecs.push_back('{mk(0, 0, 0, 1, 0, 0, 5),           32'h00500093, 1'b0});
        vecs.push_back('{mk(1, 0, 1, 3, 1, 2, 0),           32'h402081B3, 1'b0});
        vecs.push_back('{mk(4, 0, 0, 0, 1, 2, 8),           32'h00208463, 1'b0});
        vecs.push_back('{mk(2, 2, 0, 6, 2, 0, -4),          32'hFFC12303, 1'b0});
        vecs.push_back('{mk(3, 2, 0, 0, 2, 5, 8),           32'h00512423, 1'b0});
        vecs.push_back('{mk(5, 0, 0, 1, 0, 0, 2048),        32'h001000EF, 1'b0});
        vecs.push_back('{mk(6, 3, 0, 0, 1, 0, 0),           32'h00008067, 1'b0});
        vecs.push_back('{mk(7, 0, 0, 10, 0, 0, 'hABCDE123), 32'hABCDE537, 1'b0});
        vecs.push_back('{mk(8, 0, 0, 2, 0, 0, 'h1000),      32'h00001117, 1'b0});
        vecs.push_back('{mk(0, 5, 1, 4, 4, 0, 3),           32'h40325213, 1'b0});
        vecs.push_back('{mk(4, 1, 0, 0, 1, 0, -4),          32'hFE009EE3, 1'b0});
        vecs.push_back('{mk(0, 0, 0, 1, 0, 0, -2048),       32'h80000093, 1'b0});
        vecs.push_back('{mk(4, 0, 0, 0, 0, 0, 4094),        32'h7E000FE3, 1'b0});
        vecs.push_back('{mk(4, 0, 0, 0, 0, 0, -4096),       32'h80000063, 1'b0});
        vecs.push_back('{mk(0, 0, 0, 1, 0, 0, 2048),        32'h0, 1'b1});
        vecs.push_back('{mk(4, 0, 0, 0, 1, 2, 7),           32'h0, 1'b1});
        vecs.push_back('{mk(12, 0, 0, 1, 0, 0, 0),          32'h0, 1'b1});
        vecs.push_back('{mk(2, 3, 0, 1, 0, 0, 0),           32'h0, 1'b1});
        vecs.push_back('{mk(3, 3, 0, 0, 1, 2, 0),           32'h0, 1'b1});
        vecs.push_back('{mk(4, 2, 0, 0, 1, 2, 8),           32'h0, 1'b1});
        vecs.push_back('{mk(0, 0, 1, 1, 0, 0, 1),           32'h0, 1'b1});
        vecs.push_back('{mk(0, 1, 0, 1, 1, 0, 32),          32'h0, 1'b1});
        vecs.push_back('{mk(5, 0, 0, 1, 0, 0, 1048576),     32'h0, 1'b1});
`ifdef INSTR_ENC_LI_EN
        vecs.push_back('{mk(9, 0, 0, 7, 0, 0, -1),          32'hFFF00393, 1'b0});
        vecs.push_back('{mk(9, 0, 0, 8, 0, 0, 'h5000),      32'h00005437, 1'b0});
`else
        vecs.push_back('{mk(9, 0, 0, 7, 0, 0, -1),          32'h0, 1'b1});
`endif

        bus.req_valid = 1'b0; bus.out_ready = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0));
        bus2.req_valid = 1'b0; bus2.out_ready = 1'b0; bus2.req_kind = 4'd0;
        bus2.req_funct3 = 3'd0; bus2.req_alt = 1'b0; bus2.req_rd = 5'd1;
        bus2.req_rs1 = 5'd0; bus2.req_rs2 = 5'd0; bus2.req_imm = 32'd5;

        // Reset state while rst is held.
        @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_addr", 32'(bus.out_addr), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ADDI x1,x0,5 straight after reset.
        bus.out_ready = 1'b1;
        send(mk(0, 0, 0, 1, 0, 0, 5));
        check("addi_valid", 32'(bus.out_valid), 32'd1);
        check("addi_instr", bus.out_instr, 32'h00500093);
        check("addi_addr", 32'(bus.out_addr), 32'd0);

        // SUB then BEQ back-to-back.
        do_reset();
        send(mk(1, 0, 1, 3, 1, 2, 0));
        check("sub_instr", bus.out_instr, 32'h402081B3);
        check("sub_addr", 32'(bus.out_addr), 32'd0);
        send(mk(4, 0, 0, 0, 1, 2, 8));
        check("beq_instr", bus.out_instr, 32'h00208463);
        check("beq_addr", 32'(bus.out_addr), 32'd1);

        // Three illegal requests, then a legal one still lands at address 0.
        do_reset();
        send(mk(0, 0, 0, 1, 0, 0, 2048));
        check("ill1_err", 32'(bus.err), 32'd1);
        check("ill1_valid", 32'(bus.out_valid), 32'd0);
        send(mk(4, 0, 0, 0, 1, 2, 7));
        check("ill2_err", 32'(bus.err), 32'd1);
        send(mk(12, 0, 0, 1, 0, 0, 0));
        check("ill3_err", 32'(bus.err), 32'd1);
        check("ill3_valid", 32'(bus.out_valid), 32'd0);
        send(mk(0, 0, 0, 1, 0, 0, 5));
        check("post_ill_err", 32'(bus.err), 32'd0);
        check("post_ill_addr", 32'(bus.out_addr), 32'd0);
        check("post_ill_instr", bus.out_instr, 32'h00500093);

`ifdef INSTR_ENC_LI_EN
        // LI expansion with the consumer stalled after the first word.
        do_reset();
        bus.out_ready = 1'b0;
        send(mk(9, 0, 0, 5, 0, 0, 'h12345FFF));
        for (int i = 0; i < 4; i++) begin
            check("li_hi_instr", bus.out_instr, 32'h123462B7);
            check("li_hi_addr", 32'(bus.out_addr), 32'd0);
            check("li_hi_ready", 32'(bus.req_ready), 32'd0);
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("li_lo_instr", bus.out_instr, 32'h FFF28293);
        check("li_lo_addr", 32'(bus.out_addr), 32'd1);
        check("li_lo_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        check("li_done_valid", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of an LI expansion drops the pending ADDI.
        do_reset();
        bus.out_ready = 1'b0;
        send(mk(9, 0, 0, 5, 0, 0, 'h12345FFF));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("li_rst_valid", 32'(bus.out_valid), 32'd0);
        check("li_rst_addr", 32'(bus.out_addr), 32'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("li_rst_no_addi", 32'(bus.out_valid), 32'd0);
`else
        do_reset();
        send(mk(9, 0, 0, 5, 0, 0, 'h12345FFF));
        check("li_off_err", 32'(bus.err), 32'd1);
        check("li_off_valid", 32'(bus.out_valid), 32'd0);
`endif

        // Address wrap on a 2-bit counter.
        do_reset();
        bus2.out_ready = 1'b1;
        bus2.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("wrap_valid", 32'(bus2.out_valid), 32'd1);
            check("wrap_addr", 32'(bus2.out_addr), 32'(i % 4));
        end
        bus2.req_valid = 1'b0;

        // Table vectors.
        do_reset();
        bus.out_ready = 1'b1;
        foreach (vecs[i]) begin
            v = vecs[i];
            send(v.r);
            check($sformatf("vec%0d_err", i), 32'(bus.err), 32'(v.bad));
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(!v.bad));
            if (!v.bad) check($sformatf("vec%0d_instr", i), bus.out_instr, v.instr);
        end

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            drive(mk(($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15))
                                                 : int'($urandom_range(0, 9)),
                     int'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0) ? 1 : 0,
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), rand_imm()));
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drain_pending", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by t=%0t, expected $finish earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
